// File: rtl/clock_gen_pkg.sv
// rtl/clock_gen_pkg.sv - shared state type and mode constants for the CPU clock generator
package clock_gen_pkg;

  typedef enum logic [2:0] {
    STOP,
    RUN_HIGH,
    RUN_LOW,
    STEP_HIGH,
    STEP_LOW
  } clk_state_t;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;

  function automatic logic is_high_phase(input clk_state_t s);
    return (s == RUN_HIGH) || (s == STEP_HIGH);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - step button synchroniser, debouncer and rising-edge pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DEBOUNCE_W      = 16
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic rise_pulse
);

  localparam logic [DEBOUNCE_W-1:0] LAST_CNT = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  logic                  sync1_q, sync2_q;
  logic                  level_q, level_d;
  logic                  rise_q, rise_d;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

  // The count only advances while the synchronised input disagrees with the level,
  // so any bounce back to the current level restarts it from zero.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST_CNT) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/clock_gen.sv
// rtl/clock_gen.sv - programmable, glitch-free CPU clock with single-step and HLT stop
// Optional cycle_count output when CLK_CYCLE_COUNT_EN is defined.
module clock_gen
  import clock_gen_pkg::*;
#(
  parameter int DIV_W           = 24,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DEBOUNCE_W      = 16
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             button,
  input  logic             halt,
  input  logic [DIV_W-1:0] half_period,
  output logic             cpu_clk,
  output logic             cpu_rise,
  output logic             cpu_fall,
`ifdef CLK_CYCLE_COUNT_EN
  output logic [31:0]      cycle_count,
`endif
  output logic             running
);

  clk_state_t       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] len_q, len_d;
  logic             clk_q, rise_q, fall_q;
  logic             btn_level, btn_rise, step_req;
  logic             phase_end, start_phase, next_high;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DEBOUNCE_W      (DEBOUNCE_W)
  ) u_button_debounce (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .button     (button),
    .level      (btn_level),
    .rise_pulse (btn_rise)
  );

  assign step_req  = btn_rise & btn_level;
  assign phase_end = (cnt_q == len_q);

  // mode/halt are only looked at in STOP or at the end of a low phase, so a
  // high phase always runs to completion.
  always_comb begin
    state_d     = state_q;
    start_phase = 1'b0;
    case (state_q)
      STOP: begin
        if (!halt) begin
          if (mode == MODE_CONT) begin
            state_d     = RUN_HIGH;
            start_phase = 1'b1;
          end else if (step_req) begin
            state_d     = STEP_HIGH;
            start_phase = 1'b1;
          end
        end
      end
      RUN_HIGH: begin
        if (phase_end) begin
          state_d     = RUN_LOW;
          start_phase = 1'b1;
        end
      end
      RUN_LOW: begin
        if (phase_end) begin
          if (mode == MODE_CONT && !halt) begin
            state_d     = RUN_HIGH;
            start_phase = 1'b1;
          end else begin
            state_d = STOP;
          end
        end
      end
      STEP_HIGH: begin
        if (phase_end) begin
          state_d     = STEP_LOW;
          start_phase = 1'b1;
        end
      end
      STEP_LOW: begin
        if (phase_end) begin
          state_d = STOP;
        end
      end
      default: state_d = STOP;
    endcase

    cnt_d = cnt_q + 1'b1;
    len_d = len_q;
    if (start_phase) begin
      cnt_d = '0;
      len_d = half_period;
    end else if (state_d == STOP) begin
      cnt_d = '0;
    end
    next_high = is_high_phase(state_d);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= STOP;
      cnt_q   <= '0;
      len_q   <= '0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      clk_q   <= next_high;
      rise_q  <= next_high & ~clk_q;
      fall_q  <= ~next_high & clk_q;
    end
  end

  assign cpu_clk  = clk_q;
  assign cpu_rise = rise_q;
  assign cpu_fall = fall_q;
  assign running  = (state_q != STOP);

`ifdef CLK_CYCLE_COUNT_EN
  logic [31:0] cycle_count_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cycle_count_q <= '0;
    end else if (next_high && !clk_q) begin
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_clock_gen.sv
// tb/tb_clock_gen.sv - self-checking bench for clock_gen against a phase-queue reference model
module tb_clock_gen;

  localparam int DIV_W = 24;
  localparam int DB    = 4;
  localparam int DBW   = 16;

  localparam int K_IDLE    = 0;
  localparam int K_RUN_HI  = 1;
  localparam int K_RUN_LO  = 2;
  localparam int K_STEP_HI = 3;
  localparam int K_STEP_LO = 4;

  logic             sys_clk = 1'b0;
  logic             rst, mode, button, halt;
  logic [DIV_W-1:0] half_period;
  logic             cpu_clk, cpu_rise, cpu_fall, running;
`ifdef CLK_CYCLE_COUNT_EN
  logic [31:0]      cycle_count;
`endif

  int checks   = 0;
  int failures = 0;

  clock_gen #(
    .DIV_W           (DIV_W),
    .DEBOUNCE_CYCLES (DB),
    .DEBOUNCE_W      (DBW)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .mode        (mode),
    .button      (button),
    .halt        (halt),
    .half_period (half_period),
    .cpu_clk     (cpu_clk),
    .cpu_rise    (cpu_rise),
    .cpu_fall    (cpu_fall),
`ifdef CLK_CYCLE_COUNT_EN
    .cycle_count (cycle_count),
`endif
    .running     (running)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: button history -> debounce window -> queue of future cpu_clk levels.
  bit          bq[$];
  bit          win[$];
  bit          lvl[$];
  int          kind;
  bit          m_level, m_step, m_valid;
  bit          m_clk, m_rise, m_fall, m_run;
  logic [31:0] m_cnt;
  bit          s_v, step_use, prev_clk, all_diff;

  task automatic push_phase(input bit v, input int k);
    for (int i = 0; i <= int'(half_period); i++) lvl.push_back(v);
    kind = k;
  endtask

  always @(posedge sys_clk) begin
    if (rst) begin
      bq.delete(); bq.push_back(1'b0); bq.push_back(1'b0);
      win.delete();
      for (int i = 0; i < DB; i++) win.push_back(1'b0);
      lvl.delete();
      kind = K_IDLE;
      m_level = 0; m_step = 0; m_clk = 0; m_rise = 0; m_fall = 0; m_run = 0;
      m_cnt = '0; m_valid = 1;
    end else if (m_valid) begin
      step_use = m_step;
      s_v = bq.pop_front();
      bq.push_back(button);
      void'(win.pop_front());
      win.push_back(s_v);
      all_diff = 1'b1;
      foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
      m_step = 0;
      if (all_diff) begin
        m_level = !m_level;
        m_step  = m_level;
      end
      if (lvl.size() == 0) begin
        case (kind)
          K_RUN_HI:  push_phase(1'b0, K_RUN_LO);
          K_STEP_HI: push_phase(1'b0, K_STEP_LO);
          K_STEP_LO: kind = K_IDLE;
          K_RUN_LO:  if (!mode && !halt) push_phase(1'b1, K_RUN_HI); else kind = K_IDLE;
          default: begin
            if (!halt && !mode) push_phase(1'b1, K_RUN_HI);
            else if (!halt && mode && step_use) push_phase(1'b1, K_STEP_HI);
          end
        endcase
      end
      prev_clk = m_clk;
      if (lvl.size() != 0) begin
        m_clk = lvl.pop_front();
        m_run = 1;
      end else begin
        m_clk = 0;
        m_run = 0;
      end
      m_rise = m_clk & !prev_clk;
      m_fall = !m_clk & prev_clk;
      if (m_rise) m_cnt = m_cnt + 32'd1;
    end
  end

  always @(negedge sys_clk) begin
    if (m_valid) begin
      check("cpu_clk", cpu_clk, m_clk);
      check("cpu_rise", cpu_rise, m_rise);
      check("cpu_fall", cpu_fall, m_fall);
      check("running", running, m_run);
`ifdef CLK_CYCLE_COUNT_EN
      check("cycle_count", cycle_count, m_cnt);
`endif
    end
  end

  task automatic wait_rise(output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (cpu_rise !== 1'b1 && n < 200);
    if (n >= 200) check("rise_timeout", 0, 1);
  endtask

  task automatic run_len(input logic v, output int n);
    n = 0;
    while (cpu_clk === v && n < 1000) begin
      n++;
      @(negedge sys_clk);
    end
  endtask

  task automatic count_rises(input int cycles, output int r);
    r = 0;
    repeat (cycles) begin
      @(negedge sys_clk);
      r += int'(cpu_rise);
    end
  endtask

  int n, h, l, r;

  initial begin
    rst = 1; mode = 0; halt = 0; button = 0; half_period = 3;
    repeat (3) @(negedge sys_clk);
    check("reset_cpu_clk", cpu_clk, 0);
    check("reset_running", running, 0);
    check("reset_rise", cpu_rise, 0);
    check("reset_fall", cpu_fall, 0);
    rst = 0;

    wait_rise(n);
    check("start_latency", n, 1);
    run_len(1'b1, h); check("hp3_high", h, 4);
    run_len(1'b0, l); check("hp3_low", l, 4);

    half_period = 1;
    run_len(1'b1, h); check("hp_change_high", h, 4);
    run_len(1'b0, l); check("hp_change_low", l, 2);
    run_len(1'b1, h); check("hp1_high", h, 2);

    half_period = 3;
    wait_rise(n);
    @(negedge sys_clk);
    halt = 1;
    run_len(1'b1, h); check("halt_high_rest", h, 3);
    repeat (4) @(negedge sys_clk);
    check("halt_stopped", running, 0);
    check("halt_clk_low", cpu_clk, 0);
    repeat (5) @(negedge sys_clk);
    halt = 0;
    @(negedge sys_clk);
    check("halt_release_rise", cpu_rise, 1);

    @(negedge sys_clk);
    mode = 1;
    count_rises(30, r);
    check("mode_switch_no_rise", r, 0);
    check("mode_switch_stopped", running, 0);

    half_period = 20;
    button = 1; @(negedge sys_clk);
    button = 0; @(negedge sys_clk);
    button = 1;
    wait_rise(n);
    check("step_latency", n, 7);
    button = 0;
    run_len(1'b1, h); check("step_high", h, 21);
    button = 1;
    count_rises(45, r);
    check("step_low_press_ignored", r, 0);
    check("step_done_stopped", running, 0);
    button = 0;
    repeat (10) @(negedge sys_clk);

`ifdef CLK_CYCLE_COUNT_EN
    rst = 1; mode = 0; half_period = 1;
    @(negedge sys_clk);
    rst = 0;
    for (int i = 0; i < 10; i++) wait_rise(n);
    check("cycle_count_10", cycle_count, 10);
    rst = 1;
    @(negedge sys_clk);
    check("cycle_count_rst", cycle_count, 0);
    rst = 0;
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) < 3) mode = ~mode;
      if ($urandom_range(0, 99) < 2) halt = ~halt;
      if ($urandom_range(0, 99) < 5) half_period = DIV_W'($urandom_range(0, 4));
      if ($urandom_range(0, 99) < 15) button = ~button;
    end
    rst = 0;
    repeat (5) @(negedge sys_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
